// File: rtl/nand_cpu_pkg.sv
// Shared definitions for the nand_cpu interrupt path.
//   irq_state_t     : controller state (IDLE, REQ, SERVICE)
//   irq_id_w()      : width of a source id for a given source count
//   irq_vector_calc : handler PC for a source id, truncated to `PC_SIZE bits
// `PC_SIZE defaults to 8 when the build does not provide it.
`ifndef PC_SIZE
`define PC_SIZE 8
`endif

package nand_cpu_pkg;

  localparam int unsigned PcW = `PC_SIZE;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SERVICE
  } irq_state_t;

  function automatic int unsigned irq_id_w(input int unsigned num_src);
    return (num_src > 1) ? $clog2(num_src) : 1;
  endfunction

  function automatic logic [PcW-1:0] irq_vector_calc(input int unsigned base,
                                                      input int unsigned stride,
                                                      input int unsigned id);
    int unsigned full;
    full = base + id * stride;
    return full[PcW-1:0];
  endfunction

endpackage

// File: rtl/irq_priority_select.sv
// Combinational source selector.
//   eligible_i : one bit per source that may be requested
//   start_i    : index searched first; search proceeds upward and wraps
//   found_o    : at least one eligible source
//   id_o       : first eligible source at or after start_i (0 when none)
module irq_priority_select
  import nand_cpu_pkg::*;
#(
  parameter int unsigned NumSrc = 4,
  parameter int unsigned IdW    = irq_id_w(NumSrc)
) (
  input  logic [NumSrc-1:0] eligible_i,
  input  logic [IdW-1:0]    start_i,
  output logic              found_o,
  output logic [IdW-1:0]    id_o
);

  int unsigned idx;

  always_comb begin
    found_o = 1'b0;
    id_o    = '0;
    idx     = 0;
    for (int unsigned off = 0; off < NumSrc; off++) begin
      idx = 32'(start_i) + off;
      // start_i < NumSrc, so a single subtraction is enough to wrap
      if (idx >= NumSrc) begin
        idx = idx - NumSrc;
      end
      if (!found_o && eligible_i[idx[IdW-1:0]]) begin
        found_o = 1'b1;
        id_o    = idx[IdW-1:0];
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller feeding the fetch unit's interrupt_handler port.
// Rising edges on irq_src set pending bits; pending & mask (gated by global_en)
// is arbitrated and one vector is offered via irq_req/irq_ack. The accepted
// source stays in service until irq_ret; no nesting.
// Ports:
//   clk, n_rst            : clock, asynchronous active-low reset
//   irq_src               : raw request lines (rising-edge triggered)
//   mask_wr, mask_data    : mask register load (1 = source enabled)
//   global_en             : global interrupt enable
//   irq_req, irq_vector   : request and handler PC to fetch unit
//   irq_ack               : fetch unit took the redirect
//   irq_ret               : return-from-interrupt decoded
//   in_service, active_id : handler running / id of requested or served source
//   pending               : pending register
// Optional build macro IRQ_ROUND_ROBIN_EN: selection starts after the last
// acknowledged source instead of fixed lowest-index priority.
`ifndef PC_SIZE
`define PC_SIZE 8
`endif

module irq_controller
  import nand_cpu_pkg::*;
#(
  parameter int unsigned NUM_SRC    = 4,
  parameter int unsigned VEC_BASE   = 'h40,
  parameter int unsigned VEC_STRIDE = 4
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic [NUM_SRC-1:0]            irq_src,
  input  logic                          mask_wr,
  input  logic [NUM_SRC-1:0]            mask_data,
  input  logic                          global_en,
  output logic                          irq_req,
  output logic [`PC_SIZE-1:0]           irq_vector,
  input  logic                          irq_ack,
  input  logic                          irq_ret,
  output logic                          in_service,
  output logic [irq_id_w(NUM_SRC)-1:0]  active_id,
  output logic [NUM_SRC-1:0]            pending
);

  localparam int unsigned IdW = irq_id_w(NUM_SRC);

  irq_state_t         state_q, state_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] src_q;
  logic [NUM_SRC-1:0] rise, eligible, ack_clr;
  logic [IdW-1:0]     id_q, id_d;
  logic [IdW-1:0]     start, sel_id;
  logic               sel_found;

  always_comb begin
    rise     = irq_src & ~src_q;
    eligible = global_en ? (pending_q & mask_q) : '0;
  end

`ifdef IRQ_ROUND_ROBIN_EN
  logic [IdW-1:0] last_q, last_d;

  always_comb begin
    last_d = last_q;
    if (state_q == REQ && irq_ack) begin
      last_d = id_q;
    end
    start = (32'(last_q) + 32'd1 >= NUM_SRC) ? '0 : last_q + IdW'(1);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      last_q <= '0;
    end else begin
      last_q <= last_d;
    end
  end
`else
  assign start = '0;
`endif

  irq_priority_select #(
    .NumSrc (NUM_SRC),
    .IdW    (IdW)
  ) u_select (
    .eligible_i (eligible),
    .start_i    (start),
    .found_o    (sel_found),
    .id_o       (sel_id)
  );

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    ack_clr = '0;
    unique case (state_q)
      IDLE: begin
        if (sel_found) begin
          id_d    = sel_id;
          state_d = REQ;
        end
      end
      REQ: begin
        // ack takes priority over a simultaneous withdrawal
        if (irq_ack) begin
          ack_clr[id_q] = 1'b1;
          state_d       = SERVICE;
        end else if (!eligible[id_q]) begin
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (irq_ret) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // a new edge on the acked source keeps it pending
    pending_d = (pending_q & ~ack_clr) | rise;
    mask_d    = mask_wr ? mask_data : mask_q;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      mask_q    <= '0;
      src_q     <= '0;
      id_q      <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      src_q     <= irq_src;
      id_q      <= id_d;
    end
  end

  always_comb begin
    irq_req    = (state_q == REQ);
    in_service = (state_q == SERVICE);
    active_id  = id_q;
    pending    = pending_q;
    // id_q only changes in IDLE, so the vector is stable while requesting
    irq_vector = irq_vector_calc(VEC_BASE, VEC_STRIDE, 32'(id_q));
  end

endmodule

// File: tb/tb_irq_controller.sv
`ifndef PC_SIZE
`define PC_SIZE 8
`endif

module tb_irq_controller;

  logic                clk = 1'b0;
  logic                n_rst;
  logic [3:0]          irq_src;
  logic                mask_wr;
  logic [3:0]          mask_data;
  logic                global_en;
  logic                irq_req;
  logic [`PC_SIZE-1:0] irq_vector;
  logic                irq_ack;
  logic                irq_ret;
  logic                in_service;
  logic [1:0]          active_id;
  logic [3:0]          pending;

  int checks   = 0;
  int failures = 0;

  // Reference model: plain flags and bit arrays following the written rules
  bit       m_req, m_svc;
  bit [1:0] m_id, m_last;
  bit [3:0] m_pend, m_mask, m_prev;

  irq_controller #(
    .NUM_SRC    (4),
    .VEC_BASE   ('h40),
    .VEC_STRIDE (4)
  ) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .irq_src    (irq_src),
    .mask_wr    (mask_wr),
    .mask_data  (mask_data),
    .global_en  (global_en),
    .irq_req    (irq_req),
    .irq_vector (irq_vector),
    .irq_ack    (irq_ack),
    .irq_ret    (irq_ret),
    .in_service (in_service),
    .active_id  (active_id),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_vec(input bit [1:0] id);
    bit [31:0] pc;
    pc = 32'h40 + 32'(id) * 32'd4;
    return pc[7:0];
  endfunction

  function automatic int pick(input bit [3:0] elig);
    int start;
    int idx;
`ifdef IRQ_ROUND_ROBIN_EN
    start = (int'(m_last) + 1) % 4;
`else
    start = 0;
`endif
    for (int k = 0; k < 4; k++) begin
      idx = (start + k) % 4;
      if (elig[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_req  = 1'b0;
    m_svc  = 1'b0;
    m_id   = 2'd0;
    m_last = 2'd0;
    m_pend = 4'b0;
    m_mask = 4'b0;
    m_prev = 4'b0;
  endtask

  task automatic model_edge();
    bit [3:0] rise, elig, clr;
    int p;
    rise = irq_src & ~m_prev;
    elig = global_en ? (m_pend & m_mask) : 4'b0;
    clr  = 4'b0;
    if (m_svc) begin
      if (irq_ret) m_svc = 1'b0;
    end else if (m_req) begin
      if (irq_ack) begin
        clr[m_id] = 1'b1;
        m_req     = 1'b0;
        m_svc     = 1'b1;
        m_last    = m_id;
      end else if (!elig[m_id]) begin
        m_req = 1'b0;
      end
    end else begin
      p = pick(elig);
      if (p >= 0) begin
        m_id  = 2'(p);
        m_req = 1'b1;
      end
    end
    m_pend = (m_pend & ~clr) | rise;
    if (mask_wr) m_mask = mask_data;
    m_prev = irq_src;
  endtask

  task automatic compare_all();
    check("req", 32'(irq_req), 32'(m_req));
    check("svc", 32'(in_service), 32'(m_svc));
    check("id", 32'(active_id), 32'(m_id));
    check("vec", 32'(irq_vector), 32'(exp_vec(m_id)));
    check("pend", 32'(pending), 32'(m_pend));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic pulse_reset();
    // called at posedge+1; assert and release away from any clock edge
    #3;
    n_rst = 1'b0;
    #1;
    model_reset();
    check("rst_svc", 32'(in_service), 32'd0);
    check("rst_req", 32'(irq_req), 32'd0);
    check("rst_pend", 32'(pending), 32'd0);
    check("rst_vec", 32'(irq_vector), 32'h40);
    #1;
    n_rst = 1'b1;
  endtask

  logic [1:0] first_id, second_id;

  initial begin
`ifdef IRQ_ROUND_ROBIN_EN
    first_id  = 2'd3;
    second_id = 2'd1;
`else
    first_id  = 2'd1;
    second_id = 2'd3;
`endif
    n_rst     = 1'b1;
    irq_src   = 4'b0;
    mask_wr   = 1'b0;
    mask_data = 4'b0;
    global_en = 1'b0;
    irq_ack   = 1'b0;
    irq_ret   = 1'b0;
    model_reset();
    #1 n_rst = 1'b0;
    #6;
    check("reset_req", 32'(irq_req), 32'd0);
    check("reset_svc", 32'(in_service), 32'd0);
    check("reset_id", 32'(active_id), 32'd0);
    check("reset_vec", 32'(irq_vector), 32'h40);
    check("reset_pend", 32'(pending), 32'd0);
    #1 n_rst = 1'b1;

    // Basic request on source 2
    mask_wr = 1'b1; mask_data = 4'b1111; global_en = 1'b1;
    step();
    mask_wr = 1'b0; irq_src = 4'b0100;
    step();
    check("basic_pend", 32'(pending), 32'h4);
    irq_src = 4'b0;
    step();
    check("basic_req", 32'(irq_req), 32'd1);
    check("basic_vec", 32'(irq_vector), 32'h48);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    check("basic_svc", 32'(in_service), 32'd1);
    check("basic_clr", 32'(pending), 32'd0);
    irq_ret = 1'b1;
    step();
    irq_ret = 1'b0;
    check("basic_ret", 32'(in_service), 32'd0);

    // Two sources at once
    irq_src = 4'b1010;
    step();
    irq_src = 4'b0;
    step();
    check("prio1_id", 32'(active_id), 32'(first_id));
    check("prio1_vec", 32'(irq_vector), 32'(exp_vec(first_id)));
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0; irq_ret = 1'b1;
    step();
    irq_ret = 1'b0;
    step();
    check("prio2_id", 32'(active_id), 32'(second_id));
    check("prio2_vec", 32'(irq_vector), 32'(exp_vec(second_id)));
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0; irq_ret = 1'b1;
    step();
    irq_ret = 1'b0;

    // Mask withdraw and reissue on source 0
    irq_src = 4'b0001;
    step();
    irq_src = 4'b0;
    step();
    check("mask_req", 32'(irq_req), 32'd1);
    mask_wr = 1'b1; mask_data = 4'b1110;
    step();
    mask_wr = 1'b0;
    step();
    check("mask_drop", 32'(irq_req), 32'd0);
    check("mask_keep", 32'(pending[0]), 32'd1);
    mask_wr = 1'b1; mask_data = 4'b1111;
    step();
    mask_wr = 1'b0;
    step();
    check("mask_reissue", 32'(irq_req), 32'd1);
    check("mask_vec", 32'(irq_vector), 32'h40);

    // Ack races global disable: ack wins
    irq_ack = 1'b1; global_en = 1'b0;
    step();
    irq_ack = 1'b0; global_en = 1'b1;
    check("race_svc", 32'(in_service), 32'd1);
    check("race_clr", 32'(pending[0]), 32'd0);
    irq_ret = 1'b1;
    step();
    irq_ret = 1'b0;

    // New edge coincident with ack keeps the source pending
    irq_src = 4'b0100;
    step();
    irq_src = 4'b0;
    step();
    irq_src = 4'b0100; irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    check("retrig_pend", 32'(pending[2]), 32'd1);
    irq_ret = 1'b1;
    step();
    irq_ret = 1'b0;
    step();
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    step();
    step();
    check("held_nopend", 32'(pending[2]), 32'd0);
    irq_src = 4'b0;
    irq_ret = 1'b1;
    step();
    irq_ret = 1'b0;

    // Async reset while in service with something else pending
    irq_src = 4'b0010;
    step();
    irq_src = 4'b0;
    step();
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0; irq_src = 4'b1000;
    step();
    check("svc_before_rst", 32'(in_service), 32'd1);
    irq_src = 4'b0;
    pulse_reset();

    // Randomized traffic against the model
    for (int cyc = 0; cyc < 3000; cyc++) begin
      irq_src   = irq_src ^ 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      mask_wr   = ($urandom_range(0, 9) == 0);
      mask_data = 4'($urandom_range(0, 15));
      global_en = ($urandom_range(0, 9) != 0);
      irq_ack   = ($urandom_range(0, 1) == 1);
      irq_ret   = ($urandom_range(0, 3) == 0);
      step();
      if ($urandom_range(0, 299) == 0) begin
        pulse_reset();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
